membank_cfg_loader: RTL

- Programming-side stage that feeds the memory-bank configuration ports (bl/wl) of a routing tile such as a connection block: 72 bit-lines, 72 word-lines, 4-bit mux SRAM groups.
- Accepts a word stream of configuration data over a valid/ready handshake and assembles one full bit-line frame per word-line row.
- Drives the frame onto bl and pulses exactly one wl bit, row by row, until all rows are written; then reports done.

---
 rtl/membank_cfg_pkg.sv | 17 +
 rtl/membank_wl_driver.sv | 17 +
 rtl/membank_cfg_loader.sv | 101 ++++++++++
 3 files changed

// File: rtl/membank_cfg_pkg.sv
// membank_cfg_pkg: shared state encoding, default widths and frame sizing for the bl/wl loader.
// MEMBANK_CFG_PARITY_EN adds the ERROR state.
package membank_cfg_pkg;
  localparam int DEF_BL_WIDTH   = 72;
  localparam int DEF_WL_WIDTH   = 72;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_WL_PULSE   = 2;
  typedef enum logic [2:0] {
    IDLE, LOAD, WRITE, HOLD, DONE
`ifdef MEMBANK_CFG_PARITY_EN
    , ERROR
`endif
  } state_t;
  function automatic int words_per_frame(input int bl_width, input int data_width);
    return bl_width / data_width;
  endfunction
endpackage

// File: rtl/membank_wl_driver.sv
// membank_wl_driver: registered one-hot word-line driver, cleared asynchronously on pReset.
module membank_wl_driver #(
  parameter int WL_WIDTH = 72,
  parameter int RW       = 7
) (
  input  logic                prog_clk,
  input  logic                pReset,
  input  logic                i_en,
  input  logic [RW-1:0]       i_row,
  output logic [0:WL_WIDTH-1] o_wl
);
  logic [0:WL_WIDTH-1] r_wl;
  always_ff @(posedge prog_clk or posedge pReset)
    if (pReset) r_wl <= '0;
    else for (int j = 0; j < WL_WIDTH; j++) r_wl[j] <= i_en && (i_row == RW'(j));
  assign o_wl = r_wl;
endmodule

// File: rtl/membank_cfg_loader.sv
// membank_cfg_loader: assembles bl frames from a valid/ready word stream and pulses one wl row per frame.
// Optional MEMBANK_CFG_PARITY_EN: even-parity check per word with cfg_parity/cfg_err and an ERROR state.
module membank_cfg_loader
  import membank_cfg_pkg::*;
#(
  parameter int BL_WIDTH   = DEF_BL_WIDTH,
  parameter int WL_WIDTH   = DEF_WL_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int WL_PULSE   = DEF_WL_PULSE
) (
  input  logic                  prog_clk,
  input  logic                  pReset,
  input  logic                  cfg_start,
  input  logic [DATA_WIDTH-1:0] cfg_data,
  input  logic                  cfg_valid,
`ifdef MEMBANK_CFG_PARITY_EN
  input  logic                  cfg_parity,
  output logic                  cfg_err,
`endif
  output logic                  cfg_ready,
  output logic [0:BL_WIDTH-1]   bl,
  output logic [0:WL_WIDTH-1]   wl,
  output logic                  cfg_busy,
  output logic                  cfg_done
);
  localparam int WPF = words_per_frame(BL_WIDTH, DATA_WIDTH);
  localparam int WCW = WPF > 1 ? $clog2(WPF) : 1;
  localparam int RW  = WL_WIDTH > 1 ? $clog2(WL_WIDTH) : 1;
  localparam int PW  = WL_PULSE > 1 ? $clog2(WL_PULSE) : 1;
  state_t              r_state, w_next;
  logic [WCW-1:0]      r_word;
  logic [RW-1:0]       r_row;
  logic [PW-1:0]       r_pulse;
  logic [0:BL_WIDTH-1] r_bl;
  logic w_xfer, w_par_ok, w_restart, w_last_word, w_last_row, w_last_pulse;
`ifdef MEMBANK_CFG_PARITY_EN
  assign w_par_ok  = cfg_parity == ^cfg_data;
  assign w_restart = cfg_start && (r_state == IDLE || r_state == DONE || r_state == ERROR);
  assign cfg_err   = r_state == ERROR;
`else
  assign w_par_ok  = 1'b1;
  assign w_restart = cfg_start && (r_state == IDLE || r_state == DONE);
`endif
  assign w_xfer       = r_state == LOAD && cfg_valid;
  assign w_last_word  = r_word == WCW'(WPF - 1);
  assign w_last_row   = r_row == RW'(WL_WIDTH - 1);
  assign w_last_pulse = r_pulse == PW'(WL_PULSE - 1);
  assign cfg_ready    = r_state == LOAD;
  assign cfg_busy     = r_state == LOAD || r_state == WRITE || r_state == HOLD;
  assign cfg_done     = r_state == DONE;
  assign bl           = r_bl;
  // IDLE, DONE and ERROR all fall into default: only cfg_start moves them
  always_comb begin
    w_next = r_state;
    case (r_state)
      LOAD: begin
`ifdef MEMBANK_CFG_PARITY_EN
        if (w_xfer && !w_par_ok) w_next = ERROR;
        else
`endif
        if (w_xfer && w_last_word) w_next = WRITE;
      end
      WRITE:   w_next = w_last_pulse ? HOLD : WRITE;
      HOLD:    w_next = w_last_row ? DONE : LOAD;
      default: w_next = w_restart ? LOAD : r_state;
    endcase
  end
  always_ff @(posedge prog_clk or posedge pReset)
    if (pReset) begin
      r_state <= IDLE;
      r_word  <= '0;
      r_row   <= '0;
      r_pulse <= '0;
      r_bl    <= '0;
    end else begin
      r_state <= w_next;
      if (w_restart) begin
        r_word <= '0;
        r_row  <= '0;
      end
      if (w_xfer && w_par_ok) begin
        r_word <= w_last_word ? '0 : r_word + 1'b1;
        for (int k = 0; k < WPF; k++)
          if (r_word == WCW'(k))
            for (int i = 0; i < DATA_WIDTH; i++) r_bl[k*DATA_WIDTH+i] <= cfg_data[i];
      end
      if (r_state == WRITE) r_pulse <= w_last_pulse ? '0 : r_pulse + 1'b1;
      if (r_state == HOLD && !w_last_row) begin
        r_row  <= r_row + 1'b1;
        r_word <= '0;
      end
    end
  // wl is registered, so enable on the state about to be entered to align the pulse with WRITE
  membank_wl_driver #(.WL_WIDTH(WL_WIDTH), .RW(RW)) u_wl (
    .prog_clk(prog_clk),
    .pReset  (pReset),
    .i_en    (w_next == WRITE),
    .i_row   (r_row),
    .o_wl    (wl)
  );
endmodule
